// File: rtl/keypad_scanner.sv
// keypad_scanner: 3x3 matrix scanner with per-key debounce and a 4-entry press-event queue.
module keypad_scanner #(
  parameter int DWELL_CYCLES   = 16,
  parameter int DEBOUNCE_SCANS = 8,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] row_in,
  output logic [2:0] col_out,
  output logic       key_valid,
  output logic [3:0] key_idx,
  input  logic       key_ready,
  output logic [8:0] key_held,
  output logic       key_overflow
);
  localparam int DW   = $clog2(DWELL_CYCLES);
  localparam int CW   = $clog2(DEBOUNCE_SCANS + 1);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int NW   = PW + 1;
  localparam logic [DW-1:0] DLAST = DW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] DMAX  = CW'(DEBOUNCE_SCANS);

  logic [1:0]    col_q, col_d;
  logic [2:0]    col_oh_q, col_oh_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [8:0]    stable_q, stable_d, press;
  logic [CW-1:0] dcnt_q [9];
  logic [CW-1:0] dcnt_d [9];
  logic [3:0]    mem_q [FIFO_DEPTH];
  logic [3:0]    mem_d [FIFO_DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [NW-1:0] fcnt_q, fcnt_d, free, acc;
  logic          ovf_q, ovf_d, sample, pop;

  always_comb begin
    sample   = dwell_q == DLAST;
    dwell_d  = sample ? '0 : dwell_q + 1'b1;
    col_d    = sample ? (col_q == 2'd2 ? 2'd0 : col_q + 2'd1) : col_q;
    col_oh_d = 3'b001 << col_d;
  end

  // Only the three keys of the strobed column are examined, once per dwell.
  always_comb begin
    stable_d = stable_q;
    dcnt_d   = dcnt_q;
    press    = '0;
    for (int k = 0; k < 9; k++) begin
      if (sample && col_q == 2'(k % 3)) begin
        if (row_in[k/3] == stable_q[k]) dcnt_d[k] = '0;
        else if (dcnt_q[k] == DMAX - 1'b1) begin
          dcnt_d[k]   = '0;
          stable_d[k] = ~stable_q[k];
          press[k]    = ~stable_q[k];
        end else dcnt_d[k] = dcnt_q[k] + 1'b1;
      end
    end
  end

  // Presses are accepted in ascending index order until the freed space runs out.
  always_comb begin
    pop   = (fcnt_q != '0) && key_ready;
    free  = NW'(FIFO_DEPTH) - fcnt_q + NW'(pop);
    acc   = '0;
    mem_d = mem_q;
    ovf_d = 1'b0;
    for (int k = 0; k < 9; k++) begin
      if (press[k]) begin
        if (acc < free) begin
          mem_d[wr_q + PW'(acc)] = 4'(k);
          acc = acc + 1'b1;
        end else ovf_d = 1'b1;
      end
    end
    wr_d   = wr_q + PW'(acc);
    rd_d   = rd_q + PW'(pop);
    fcnt_d = fcnt_q - NW'(pop) + acc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q    <= '0;
      col_oh_q <= 3'b001;
      dwell_q  <= '0;
      stable_q <= '0;
      dcnt_q   <= '{default: '0};
      mem_q    <= '{default: '0};
      rd_q     <= '0;
      wr_q     <= '0;
      fcnt_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      col_q    <= col_d;
      col_oh_q <= col_oh_d;
      dwell_q  <= dwell_d;
      stable_q <= stable_d;
      dcnt_q   <= dcnt_d;
      mem_q    <= mem_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      fcnt_q   <= fcnt_d;
      ovf_q    <= ovf_d;
    end
  end

  assign col_out      = col_oh_q;
  assign key_valid    = fcnt_q != '0;
  assign key_idx      = key_valid ? mem_q[rd_q] : 4'd0;
  assign key_held     = stable_q;
  assign key_overflow = ovf_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed checks with DWELL_CYCLES=4, DEBOUNCE_SCANS=3; a scan is 12 cycles.
module tb_keypad_scanner;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] row_in;
  logic [2:0] col_out;
  logic       key_valid;
  logic [3:0] key_idx;
  logic       key_ready = 1'b0;
  logic [8:0] key_held;
  logic       key_overflow;
  logic [8:0] pressed = '0;
  int         n_cmp = 0;
  int         n_err = 0;

  keypad_scanner #(.DWELL_CYCLES(4), .DEBOUNCE_SCANS(3)) dut (
    .clk(clk), .rst_n(rst_n), .row_in(row_in), .col_out(col_out), .key_valid(key_valid),
    .key_idx(key_idx), .key_ready(key_ready), .key_held(key_held), .key_overflow(key_overflow)
  );

  always #5 clk = ~clk;

  // Keypad model: a closed key drives its row only while its column is strobed.
  always_comb for (int r = 0; r < 3; r++) row_in[r] = |(pressed[3*r +: 3] & col_out);

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    step(2);
    n_cmp++; if (col_out !== 3'b001) begin n_err++; $display("FAIL rst_col got %b exp 001", col_out); end
    n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b exp 0", key_valid); end
    n_cmp++; if (key_idx !== 4'd0) begin n_err++; $display("FAIL rst_idx got %0d exp 0", key_idx); end
    n_cmp++; if (key_held !== 9'd0) begin n_err++; $display("FAIL rst_held got %h exp 0", key_held); end
    n_cmp++; if (key_overflow !== 1'b0) begin n_err++; $display("FAIL rst_ovf got %b exp 0", key_overflow); end
    rst_n = 1'b1;
  endtask

  task automatic test_scan;
    logic [2:0] exp_col;
    for (int i = 0; i < 24; i++) begin
      exp_col = 3'b001 << ((i / 4) % 3);
      n_cmp++; if (col_out !== exp_col) begin n_err++; $display("FAIL scan_col[%0d] got %b exp %b", i, col_out, exp_col); end
      n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL scan_valid[%0d] got %b exp 0", i, key_valid); end
      step(1);
    end
  endtask

  task automatic test_single_press;
    pressed = 9'h010;
    step(31);
    n_cmp++; if (key_held[4] !== 1'b0) begin n_err++; $display("FAIL sp_early_held got %b exp 0", key_held[4]); end
    step(1);
    n_cmp++; if (key_held !== 9'h010) begin n_err++; $display("FAIL sp_held got %h exp 010", key_held); end
    n_cmp++; if (key_valid !== 1'b1) begin n_err++; $display("FAIL sp_valid got %b exp 1", key_valid); end
    n_cmp++; if (key_idx !== 4'd4) begin n_err++; $display("FAIL sp_idx got %0d exp 4", key_idx); end
    step(2);
    n_cmp++; if (key_valid !== 1'b1 || key_idx !== 4'd4) begin n_err++; $display("FAIL sp_hold got %b/%0d exp 1/4", key_valid, key_idx); end
    key_ready = 1'b1;
    step(1);
    n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL sp_pop got %b exp 0", key_valid); end
    step(1);
    pressed = '0;
    step(31);
    n_cmp++; if (key_held[4] !== 1'b1) begin n_err++; $display("FAIL sp_rel_early got %b exp 1", key_held[4]); end
    step(1);
    n_cmp++; if (key_held !== 9'h000) begin n_err++; $display("FAIL sp_rel_held got %h exp 000", key_held); end
    n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL sp_rel_valid got %b exp 0", key_valid); end
    key_ready = 1'b0;
    step(4);
  endtask

  task automatic test_bounce;
    logic [4:0] pat;
    pat = 5'b11011;
    for (int s = 0; s < 5; s++) begin
      pressed[0] = pat[4-s];
      step(12);
    end
    n_cmp++; if (key_held[0] !== 1'b0) begin n_err++; $display("FAIL bounce_held got %b exp 0", key_held[0]); end
    n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL bounce_valid got %b exp 0", key_valid); end
    pressed = '0;
    step(12);
  endtask

  task automatic test_burst;
    pressed = 9'h124;
    step(35);
    n_cmp++; if (key_held !== 9'h000) begin n_err++; $display("FAIL burst_early got %h exp 000", key_held); end
    step(1);
    n_cmp++; if (key_held !== 9'h124) begin n_err++; $display("FAIL burst_held got %h exp 124", key_held); end
    n_cmp++; if (key_valid !== 1'b1 || key_idx !== 4'd2) begin n_err++; $display("FAIL burst_head got %b/%0d exp 1/2", key_valid, key_idx); end
    n_cmp++; if (key_overflow !== 1'b0) begin n_err++; $display("FAIL burst_ovf got %b exp 0", key_overflow); end
    pressed = '0;
    key_ready = 1'b1;
    step(1);
    n_cmp++; if (key_valid !== 1'b1 || key_idx !== 4'd5) begin n_err++; $display("FAIL burst_2nd got %b/%0d exp 1/5", key_valid, key_idx); end
    step(1);
    n_cmp++; if (key_valid !== 1'b1 || key_idx !== 4'd8) begin n_err++; $display("FAIL burst_3rd got %b/%0d exp 1/8", key_valid, key_idx); end
    step(1);
    n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL burst_empty got %b exp 0", key_valid); end
    key_ready = 1'b0;
    step(33);
    n_cmp++; if (key_held !== 9'h000 || key_valid !== 1'b0) begin n_err++; $display("FAIL burst_rel got %h/%b exp 000/0", key_held, key_valid); end
  endtask

  task automatic test_overflow;
    logic [3:0] exp_q [3];
    exp_q = '{4'd3, 4'd6, 4'd1};
    pressed = 9'h05B;
    step(28);
    n_cmp++; if (key_valid !== 1'b1 || key_idx !== 4'd0) begin n_err++; $display("FAIL ovf_head got %b/%0d exp 1/0", key_valid, key_idx); end
    n_cmp++; if (key_overflow !== 1'b0) begin n_err++; $display("FAIL ovf_early got %b exp 0", key_overflow); end
    step(4);
    n_cmp++; if (key_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_pulse got %b exp 1", key_overflow); end
    n_cmp++; if (key_held !== 9'h05B) begin n_err++; $display("FAIL ovf_held got %h exp 05b", key_held); end
    step(1);
    n_cmp++; if (key_overflow !== 1'b0) begin n_err++; $display("FAIL ovf_end got %b exp 0", key_overflow); end
    n_cmp++; if (key_idx !== 4'd0) begin n_err++; $display("FAIL ovf_stable got %0d exp 0", key_idx); end
    key_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      n_cmp++; if (key_valid !== 1'b1 || key_idx !== exp_q[i]) begin n_err++; $display("FAIL ovf_drain[%0d] got %b/%0d exp 1/%0d", i, key_valid, key_idx, exp_q[i]); end
    end
    step(1);
    n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL ovf_empty got %b exp 0", key_valid); end
    key_ready = 1'b0;
    pressed = '0;
    step(11);
  endtask

  task automatic test_async_reset;
    step(36);
    n_cmp++; if (key_held !== 9'h000 || key_valid !== 1'b0) begin n_err++; $display("FAIL ar_rel got %h/%b exp 000/0", key_held, key_valid); end
    pressed = 9'h024;
    step(36);
    n_cmp++; if (key_valid !== 1'b1 || key_idx !== 4'd2) begin n_err++; $display("FAIL ar_queued got %b/%0d exp 1/2", key_valid, key_idx); end
    step(9);
    n_cmp++; if (col_out !== 3'b100) begin n_err++; $display("FAIL ar_precol got %b exp 100", col_out); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL ar_valid got %b exp 0", key_valid); end
    n_cmp++; if (col_out !== 3'b001) begin n_err++; $display("FAIL ar_col got %b exp 001", col_out); end
    n_cmp++; if (key_held !== 9'h000) begin n_err++; $display("FAIL ar_held got %h exp 000", key_held); end
    n_cmp++; if (key_idx !== 4'd0) begin n_err++; $display("FAIL ar_idx got %0d exp 0", key_idx); end
    step(2);
    rst_n = 1'b1;
    step(3);
    n_cmp++; if (col_out !== 3'b001) begin n_err++; $display("FAIL ar_dwell got %b exp 001", col_out); end
    step(1);
    n_cmp++; if (col_out !== 3'b010) begin n_err++; $display("FAIL ar_adv got %b exp 010", col_out); end
    step(32);
    n_cmp++; if (key_valid !== 1'b1 || key_idx !== 4'd2) begin n_err++; $display("FAIL ar_fresh got %b/%0d exp 1/2", key_valid, key_idx); end
    n_cmp++; if (key_held !== 9'h024) begin n_err++; $display("FAIL ar_reheld got %h exp 024", key_held); end
  endtask

  initial begin
    test_reset;
    test_scan;
    test_single_press;
    test_bounce;
    test_burst;
    test_overflow;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
